// File: rtl/button_encoder.sv
// ============================================================================
// button_encoder : synchronise, debounce and encode four push-buttons into a
//                  2-bit colour code with a held-level valid.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module button_encoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  output logic [1:0] IN,
  output logic       IN_VALID
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  cand_q, cand_d;
  logic [3:0]                  stable_q, stable_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  state_t                      state_q, state_d;
  logic [1:0]                  in_q, in_d;
  logic                        in_valid_q, in_valid_d;

  logic [3:0] sync_out;
  logic       one_hot;
  logic [1:0] enc;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign IN       = in_q;
  assign IN_VALID = in_valid_q;

  always_comb begin
    sync_d[0] = BTN;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Any change of the synchronised vector restarts the stability window.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_out != cand_q) begin
      cand_d = sync_out;
    end else if (cand_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = cand_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    one_hot = (stable_q != 4'd0) && ((stable_q & (stable_q - 4'd1)) == 4'd0);
    if (stable_q[3])      enc = 2'd3;
    else if (stable_q[2]) enc = 2'd2;
    else if (stable_q[1]) enc = 2'd1;
    else                  enc = 2'd0;
  end

  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    in_valid_d = in_valid_q;
    case (state_q)
      ST_IDLE: begin
        in_valid_d = 1'b0;
        if (one_hot) begin
          in_d       = enc;
          in_valid_d = 1'b1;
          state_d    = ST_PRESSED;
        end else if (stable_q != 4'd0) begin
          state_d = ST_LOCKOUT;
        end
      end
      // First button wins: only a full release ends the press.
      ST_PRESSED: begin
        if (stable_q == 4'd0) begin
          in_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        in_valid_d = 1'b0;
        if (stable_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        in_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q     <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      in_q       <= '0;
      in_valid_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      in_q       <= in_d;
      in_valid_q <= in_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_encoder.sv
// ============================================================================
// tb_button_encoder : self-checking bench for button_encoder
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_button_encoder;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
  localparam int WAIT_BUDGET     = LAT + 12;
  localparam int QUIET           = 20;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] BTN   = 4'b0100;
  logic [1:0] IN;
  logic       IN_VALID;

  int edges = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         edge_no;
    logic [1:0] code;
    logic       valid;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edges <= edges + 1;

  button_encoder #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BTN     (BTN),
    .IN      (IN),
    .IN_VALID(IN_VALID)
  );

  // Called at a negedge; the following posedge is edge 1 for the new level.
  task automatic drive(input logic [3:0] b, input bit expect_change,
                       input logic [1:0] code, input logic vld);
    BTN = b;
    if (expect_change) sb.push_back('{edges + LAT, code, vld});
  endtask

  task automatic wait_change(input int budget, output int at_edge, output bit seen);
    logic prev;
    prev    = IN_VALID;
    seen    = 1'b0;
    at_edge = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (IN_VALID !== prev) begin
        seen    = 1'b1;
        at_edge = edges;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int e; bit seen; exp_t ex;
    RST_N = 1'b0;
    BTN   = 4'b0100;
    repeat (2) @(negedge CLK);
    total++;
    if (IN !== 2'd0 || IN_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in=%0d valid=%b expected in=0 valid=0", IN, IN_VALID);
    end
    RST_N = 1'b1;
    drive(4'b0100, 1, 2'd2, 1'b1);
    wait_change(WAIT_BUDGET, e, seen);
    ex = sb.pop_front();
    total++;
    if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
      bad++;
      $display("FAIL reset_first_press: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
               e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
    end
  endtask

  task automatic test_bounce();
    int e; bit seen; exp_t ex; bit stuck;
    drive(4'b0000, 1, 2'd2, 1'b0);
    wait_change(WAIT_BUDGET, e, seen);
    ex = sb.pop_front();
    total++;
    if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
      bad++;
      $display("FAIL bounce_pre_release: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
               e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
    end
    stuck = 1'b0;
    for (int k = 0; k < 6; k++) begin
      BTN[1] = ~BTN[1];
      repeat (2) begin
        @(negedge CLK);
        if (IN_VALID !== 1'b0) stuck = 1'b1;
      end
    end
    total++;
    if (stuck) begin
      bad++;
      $display("FAIL bounce_quiet: valid rose during toggling, expected 0 throughout");
    end
    drive(4'b0010, 1, 2'd1, 1'b1);
    wait_change(WAIT_BUDGET, e, seen);
    ex = sb.pop_front();
    total++;
    if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
      bad++;
      $display("FAIL bounce_settle: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
               e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
    end
  endtask

  task automatic test_release();
    int e; bit seen; exp_t ex;
    logic [3:0] pat [3] = '{4'b0000, 4'b1000, 4'b0000};
    logic [1:0] cod [3] = '{2'd1, 2'd3, 2'd3};
    logic       vld [3] = '{1'b0, 1'b1, 1'b0};
    for (int s = 0; s < 3; s++) begin
      drive(pat[s], 1, cod[s], vld[s]);
      wait_change(WAIT_BUDGET, e, seen);
      ex = sb.pop_front();
      total++;
      if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
        bad++;
        $display("FAIL release_step%0d: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
                 s, e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
      end
    end
    repeat (QUIET) @(negedge CLK);
    total++;
    if (IN !== 2'd3 || IN_VALID !== 1'b0) begin
      bad++;
      $display("FAIL release_hold: in=%0d valid=%b expected in=3 valid=0", IN, IN_VALID);
    end
  endtask

  task automatic test_multi();
    int e; bit seen; exp_t ex;
    drive(4'b0011, 0, 2'd0, 1'b0);
    wait_change(QUIET, e, seen);
    total++;
    if (seen || IN !== 2'd3) begin
      bad++;
      $display("FAIL multi_suppressed: change_seen=%b in=%0d expected change_seen=0 in=3", seen, IN);
    end
    drive(4'b0000, 0, 2'd0, 1'b0);
    wait_change(QUIET, e, seen);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL multi_release: change_seen=%b expected 0", seen);
    end
    drive(4'b0001, 1, 2'd0, 1'b1);
    wait_change(WAIT_BUDGET, e, seen);
    ex = sb.pop_front();
    total++;
    if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
      bad++;
      $display("FAIL multi_then_single: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
               e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
    end
  endtask

  task automatic test_first_wins();
    int e; bit seen; exp_t ex;
    logic [3:0] pat [6] = '{4'b0000, 4'b0100, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    bit         chg [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] cod [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic       vld [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 6; s++) begin
      drive(pat[s], chg[s], cod[s], vld[s]);
      if (chg[s]) begin
        wait_change(WAIT_BUDGET, e, seen);
        ex = sb.pop_front();
        total++;
        if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
          bad++;
          $display("FAIL first_wins_step%0d: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
                   s, e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
        end
      end else begin
        wait_change(QUIET, e, seen);
        total++;
        if (seen || IN !== cod[s] || IN_VALID !== vld[s]) begin
          bad++;
          $display("FAIL first_wins_hold%0d: change_seen=%b in=%0d valid=%b expected change_seen=0 in=%0d valid=%b",
                   s, seen, IN, IN_VALID, cod[s], vld[s]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e; bit seen; exp_t ex;
    drive(4'b0010, 1, 2'd1, 1'b1);
    wait_change(WAIT_BUDGET, e, seen);
    ex = sb.pop_front();
    total++;
    if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
      bad++;
      $display("FAIL reset_mid_press: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
               e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    total++;
    if (IN !== 2'd0 || IN_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_clear: in=%0d valid=%b expected in=0 valid=0", IN, IN_VALID);
    end
    RST_N = 1'b1;
    sb.push_back('{edges + LAT, 2'd1, 1'b1});
    wait_change(WAIT_BUDGET, e, seen);
    ex = sb.pop_front();
    total++;
    if (!seen || e !== ex.edge_no || IN_VALID !== ex.valid || IN !== ex.code) begin
      bad++;
      $display("FAIL reset_mid_redetect: edge=%0d in=%0d valid=%b expected edge=%0d in=%0d valid=%b",
               e, IN, IN_VALID, ex.edge_no, ex.code, ex.valid);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release();
    test_multi();
    test_first_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
